gnor_sweep_ctrl: RTL



---
 rtl/gnor_sweep_ctrl_if.sv | 39 +++
 rtl/gnor_sweep_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/gnor_sweep_ctrl_if.sv
// rtl/gnor_sweep_ctrl_if.sv - control/status bundle between the NOR sweep controller and its user
// Optional fault-log signals exist only when GNOR_SWEEP_FAULT_LOG_EN is defined.
interface gnor_sweep_ctrl_if #(
    parameter int ERR_W = 4
);
    logic             start;
    logic             abort;
    logic             y;
    logic             a;
    logic             b;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
`ifdef GNOR_SWEEP_FAULT_LOG_EN
    logic             fault_vld;
    logic [1:0]       fault_vec;

    modport master (
        output start, abort, y,
        input  a, b, busy, done, pass, err_count, fault_vld, fault_vec
    );

    modport slave (
        input  start, abort, y,
        output a, b, busy, done, pass, err_count, fault_vld, fault_vec
    );
`else
    modport master (
        output start, abort, y,
        input  a, b, busy, done, pass, err_count
    );

    modport slave (
        input  start, abort, y,
        output a, b, busy, done, pass, err_count
    );
`endif
endinterface

// File: rtl/gnor_sweep_ctrl.sv
// rtl/gnor_sweep_ctrl.sv - NOR gate truth-table sweep and self-check sequencer
// Optional first-fault capture enabled by defining GNOR_SWEEP_FAULT_LOG_EN.
module gnor_sweep_ctrl #(
    parameter int HOLD_CYCLES = 4,
    parameter int ROUNDS      = 1,
    parameter int ERR_W       = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    gnor_sweep_ctrl_if.slave     bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [7:0]       hold_cnt;
    logic [1:0]       vec;
    logic [7:0]       round_cnt;
    logic             a_q;
    logic             b_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [ERR_W-1:0] err_q;

    logic             exp_y;
    logic             mismatch;
    logic             sample;
    logic             run_start;
    logic [ERR_W-1:0] err_next;
    logic [1:0]       vec_inc;
    logic [1:0]       ab_next;

    // Gray order (a,b): 00, 10, 11, 01 -- only one gate input toggles per step.
    function automatic logic [1:0] vec_ab(input logic [1:0] v);
        case (v)
            2'd0:    vec_ab = 2'b00;
            2'd1:    vec_ab = 2'b10;
            2'd2:    vec_ab = 2'b11;
            default: vec_ab = 2'b01;
        endcase
    endfunction

    // Sample decode and saturating mismatch count for the current vector.
    always_comb begin
        exp_y     = (vec == 2'd0);
        mismatch  = (bus.y != exp_y);
        sample    = (state == S_APPLY) && !bus.abort && (hold_cnt == 8'(HOLD_CYCLES - 1));
        run_start = (state == S_IDLE) && bus.start && !bus.abort;
        vec_inc   = vec + 2'd1;
        ab_next   = vec_ab(vec_inc);
        err_next  = err_q;
        if (mismatch && (err_q != {ERR_W{1'b1}})) begin
            err_next = err_q + ERR_W'(1);
        end
    end

    // Sequencer FSM: IDLE -> APPLY (vectors x rounds) -> DONE -> IDLE, abort back to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            hold_cnt  <= 8'd0;
            vec       <= 2'd0;
            round_cnt <= 8'd0;
            a_q       <= 1'b0;
            b_q       <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (run_start) begin
                        state     <= S_APPLY;
                        busy_q    <= 1'b1;
                        hold_cnt  <= 8'd0;
                        vec       <= 2'd0;
                        round_cnt <= 8'd0;
                        {a_q, b_q} <= vec_ab(2'd0);
                        err_q     <= '0;
                        pass_q    <= 1'b0;
                    end
                end
                S_APPLY: begin
                    if (bus.abort) begin
                        state     <= S_IDLE;
                        busy_q    <= 1'b0;
                        hold_cnt  <= 8'd0;
                        vec       <= 2'd0;
                        round_cnt <= 8'd0;
                        a_q       <= 1'b0;
                        b_q       <= 1'b0;
                        pass_q    <= 1'b0;
                    end else if (sample) begin
                        err_q    <= err_next;
                        hold_cnt <= 8'd0;
                        vec      <= vec_inc;
                        if (vec == 2'd3) begin
                            if (round_cnt == 8'(ROUNDS - 1)) begin
                                state     <= S_DONE;
                                busy_q    <= 1'b0;
                                done_q    <= 1'b1;
                                pass_q    <= (err_next == '0);
                                round_cnt <= 8'd0;
                                a_q       <= 1'b0;
                                b_q       <= 1'b0;
                            end else begin
                                round_cnt  <= round_cnt + 8'd1;
                                {a_q, b_q} <= ab_next;
                            end
                        end else begin
                            {a_q, b_q} <= ab_next;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;

`ifdef GNOR_SWEEP_FAULT_LOG_EN
    logic       fault_vld_q;
    logic [1:0] fault_vec_q;

    // Capture only the first mismatching vector of a run; held until the next start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_vld_q <= 1'b0;
            fault_vec_q <= 2'b00;
        end else if (run_start) begin
            fault_vld_q <= 1'b0;
            fault_vec_q <= 2'b00;
        end else if (sample && mismatch && !fault_vld_q) begin
            fault_vld_q <= 1'b1;
            fault_vec_q <= {a_q, b_q};
        end
    end

    assign bus.fault_vld = fault_vld_q;
    assign bus.fault_vec = fault_vec_q;
`endif

endmodule
